tx_uart: RTL and testbench
==========================

// Module: tx_uart
// PURPOSE
//   UART transmitter; serializes one NB_DATA-bit word per request onto o_tx as
//   8N1-style frame: start(0), data LSB first, N_STOP_BITS stop(1).
//   Paced by the shared baud-rate generator tick (i_s_tick, N_TICKS_PER_BIT ticks/bit).
//   Sits opposite rx_uart on the same serial link; fed by the interface/ALU side.
// PARAMETERS
//   NB_DATA          8   data bits per frame
//   N_TICKS_PER_BIT  16  i_s_tick pulses per serial bit (oversampling ratio)
//   N_STOP_BITS      1   stop bits per frame (1 or 2)
//   NB_STATE         2   state register width
// PORTS
//   i_clock         in   1        system clock; all logic on posedge
//   i_reset_n       in   1        async reset, active-low
//   i_s_tick        in   1        baud tick, 1-cycle pulse from baud generator
//   i_tx_start      in   1        request: send i_data (sampled only in IDLE)
//   i_data          in   NB_DATA  word to transmit
//   o_tx            out  1        serial line, idle high, registered
//   o_busy          out  1        high whenever state != IDLE
//   o_tx_done_tick  out  1        1-cycle pulse: frame (incl. stop bits) complete
// BEHAVIOUR
//   Clock i_clock; reset i_reset_n asynchronous, active-low.
//   Reset (async, any time incl. mid-frame): state=IDLE, o_tx=1, o_busy=0,
//     o_tx_done_tick=0, tick/bit counters=0, shift reg=0. Frame aborted, no done pulse.
//   States: IDLE -> START -> DATA -> STOP -> IDLE.
//   IDLE: o_tx=1. On clock with i_tx_start=1 (tick not required): latch i_data
//     into shift reg, clear counters, go START. o_tx=0 from next cycle (1-cycle latency).
//   START: o_tx=0. Count i_s_tick; on tick with tick_cnt==N_TICKS_PER_BIT-1:
//     tick_cnt<=0, bit_cnt<=0, go DATA.
//   DATA: o_tx=shiftreg[0]. On tick with tick_cnt==N_TICKS_PER_BIT-1: tick_cnt<=0,
//     shift right; if bit_cnt==NB_DATA-1 go STOP else bit_cnt<=bit_cnt+1.
//   STOP: o_tx=1. Count ticks; on tick with tick_cnt==N_STOP_BITS*N_TICKS_PER_BIT-1:
//     go IDLE, assert o_tx_done_tick for exactly that following cycle (registered).
//   Counters advance only on cycles with i_s_tick=1; no tick -> hold.
//   tick_cnt width = $clog2(N_STOP_BITS*N_TICKS_PER_BIT); bit_cnt width =
//     $clog2(NB_DATA); no wrap beyond terminal values (terminal compare resets to 0).
//   i_tx_start while o_busy=1: ignored; i_data changes mid-frame have no effect.
//   i_tx_start in the cycle o_tx_done_tick=1: state already IDLE -> accepted
//     (back-to-back frames, no extra idle bit).
//   Bit period = N_TICKS_PER_BIT tick periods; first bit (start) may be up to
//     one tick period short/long vs. request time (tick phase not resynchronized).
//   o_tx glitch-free: driven from flop, not from combinational state decode.
// TESTING
//   1 Reset: hold i_reset_n=0 mid-DATA -> o_tx=1, o_busy=0, done=0 same cycle (async).
//   2 Tick every 4 clks, send 0x55 -> o_tx: 0,1,0,1,0,1,0,1,0,1 each 64 clks;
//     done pulse 1 cycle at ~640 clks; o_busy low after.
//   3 Send 0xA3 with N_STOP_BITS=2 -> LSB-first 1,1,0,0,0,1,0,1; stop high 128 clks;
//     rx_uart loopback returns 0xA3.
//   4 Pulse i_tx_start with 0xFF during a 0x00 frame -> frame stays 0x00, no 2nd frame.
//   5 Assert i_tx_start with 0x0F in done cycle -> next start bit begins next cycle,
//     two frames contiguous, two done pulses.
//   6 Stall i_s_tick for 100 clks mid-DATA -> o_tx and counters hold, frame resumes.

Source files
------------

// File: rtl/tx_uart.sv
// UART transmitter: one NB_DATA-bit word per request, framed as a start bit,
// data LSB first, then N_STOP_BITS stop bits. Bit timing comes from the shared
// baud tick (N_TICKS_PER_BIT ticks per serial bit). All outputs are flops.
module tx_uart #(
    parameter int NB_DATA         = 8,
    parameter int N_TICKS_PER_BIT = 16,
    parameter int N_STOP_BITS     = 1,
    parameter int NB_STATE        = 2
) (
    input  logic               i_clock,
    input  logic               i_reset_n,
    input  logic               i_s_tick,
    input  logic               i_tx_start,
    input  logic [NB_DATA-1:0] i_data,
    output logic               o_tx,
    output logic               o_busy,
    output logic               o_tx_done_tick
);

    localparam int NB_TICK = $clog2(N_STOP_BITS * N_TICKS_PER_BIT);
    localparam int NB_BIT  = $clog2(NB_DATA);

    // Terminal counts: one serial bit, the whole stop field, the last data bit.
    localparam logic [NB_TICK-1:0] BIT_LAST  = NB_TICK'(N_TICKS_PER_BIT - 1);
    localparam logic [NB_TICK-1:0] STOP_LAST = NB_TICK'(N_STOP_BITS * N_TICKS_PER_BIT - 1);
    localparam logic [NB_BIT-1:0]  DATA_LAST = NB_BIT'(NB_DATA - 1);
    localparam logic [NB_TICK-1:0] TICK_ONE  = NB_TICK'(1);
    localparam logic [NB_BIT-1:0]  BIT_ONE   = NB_BIT'(1);

    typedef enum logic [NB_STATE-1:0] {
        ST_IDLE  = NB_STATE'(0),
        ST_START = NB_STATE'(1),
        ST_DATA  = NB_STATE'(2),
        ST_STOP  = NB_STATE'(3)
    } state_t;

    state_t               state_r, state_s;
    logic [NB_TICK-1:0]   tick_cnt_r, tick_cnt_s;
    logic [NB_BIT-1:0]    bit_cnt_r, bit_cnt_s;
    logic [NB_DATA-1:0]   shift_r, shift_s;
    logic                 tx_r, tx_s;
    logic                 busy_r, busy_s;
    logic                 done_r, done_s;

    // Next-state logic: frame sequencing, tick/bit counting and data shifting.
    always_comb begin
        state_s    = state_r;
        tick_cnt_s = tick_cnt_r;
        bit_cnt_s  = bit_cnt_r;
        shift_s    = shift_r;
        done_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (i_tx_start) begin
                    shift_s    = i_data;
                    tick_cnt_s = {NB_TICK{1'b0}};
                    bit_cnt_s  = {NB_BIT{1'b0}};
                    state_s    = ST_START;
                end else begin
                    state_s    = ST_IDLE;
                end
            end
            ST_START: begin
                if (i_s_tick) begin
                    if (tick_cnt_r == BIT_LAST) begin
                        tick_cnt_s = {NB_TICK{1'b0}};
                        bit_cnt_s  = {NB_BIT{1'b0}};
                        state_s    = ST_DATA;
                    end else begin
                        tick_cnt_s = tick_cnt_r + TICK_ONE;
                    end
                end else begin
                    tick_cnt_s = tick_cnt_r;
                end
            end
            ST_DATA: begin
                if (i_s_tick) begin
                    if (tick_cnt_r == BIT_LAST) begin
                        tick_cnt_s = {NB_TICK{1'b0}};
                        shift_s    = {1'b0, shift_r[NB_DATA-1:1]};
                        if (bit_cnt_r == DATA_LAST) begin
                            state_s = ST_STOP;
                        end else begin
                            bit_cnt_s = bit_cnt_r + BIT_ONE;
                        end
                    end else begin
                        tick_cnt_s = tick_cnt_r + TICK_ONE;
                    end
                end else begin
                    tick_cnt_s = tick_cnt_r;
                end
            end
            ST_STOP: begin
                if (i_s_tick) begin
                    if (tick_cnt_r == STOP_LAST) begin
                        tick_cnt_s = {NB_TICK{1'b0}};
                        state_s    = ST_IDLE;
                        done_s     = 1'b1;
                    end else begin
                        tick_cnt_s = tick_cnt_r + TICK_ONE;
                    end
                end else begin
                    tick_cnt_s = tick_cnt_r;
                end
            end
            default: begin
                state_s    = ST_IDLE;
                tick_cnt_s = {NB_TICK{1'b0}};
                bit_cnt_s  = {NB_BIT{1'b0}};
                shift_s    = {NB_DATA{1'b0}};
            end
        endcase
    end

    // Line level and busy flag follow the state being entered, so the flops
    // present them in the same cycle the state register does.
    always_comb begin
        tx_s   = 1'b1;
        busy_s = (state_s != ST_IDLE);
        case (state_s)
            ST_IDLE:  tx_s = 1'b1;
            ST_START: tx_s = 1'b0;
            ST_DATA:  tx_s = shift_s[0];
            ST_STOP:  tx_s = 1'b1;
            default:  tx_s = 1'b1;
        endcase
    end

    // State, counters, shift register and registered outputs.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_r    <= ST_IDLE;
            tick_cnt_r <= {NB_TICK{1'b0}};
            bit_cnt_r  <= {NB_BIT{1'b0}};
            shift_r    <= {NB_DATA{1'b0}};
            tx_r       <= 1'b1;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            tick_cnt_r <= tick_cnt_s;
            bit_cnt_r  <= bit_cnt_s;
            shift_r    <= shift_s;
            tx_r       <= tx_s;
            busy_r     <= busy_s;
            done_r     <= done_s;
        end
    end

    assign o_tx           = tx_r;
    assign o_busy         = busy_r;
    assign o_tx_done_tick = done_r;

endmodule

// File: tb/tb_tx_uart.sv
// Self-checking bench for tx_uart: one instance with 1 stop bit (a), one with
// 2 stop bits (b). Baud tick every 4 clocks, so one serial bit = 64 clocks.
// The line is sampled on the falling edge of every tick cycle; each serial bit
// must hold its expected level for all 16 of its ticks.
module tb_tx_uart;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       s_tick = 1'b0;
    logic       tick_en = 1'b1;
    logic       start_a = 1'b0, start_b = 1'b0;
    logic [7:0] data_a = 8'h00, data_b = 8'h00;
    logic       tx_a, busy_a, done_a;
    logic       tx_b, busy_b, done_b;

    int errors = 0;
    int checks = 0;
    int tick_div = 0;
    int done_cnt_a = 0;
    int done_cnt_b = 0;

    tx_uart #(.NB_DATA(8), .N_TICKS_PER_BIT(16), .N_STOP_BITS(1), .NB_STATE(2)) dut_a (
        .i_clock(clk), .i_reset_n(rst_n), .i_s_tick(s_tick), .i_tx_start(start_a),
        .i_data(data_a), .o_tx(tx_a), .o_busy(busy_a), .o_tx_done_tick(done_a));

    tx_uart #(.NB_DATA(8), .N_TICKS_PER_BIT(16), .N_STOP_BITS(2), .NB_STATE(2)) dut_b (
        .i_clock(clk), .i_reset_n(rst_n), .i_s_tick(s_tick), .i_tx_start(start_b),
        .i_data(data_b), .o_tx(tx_b), .o_busy(busy_b), .o_tx_done_tick(done_b));

    always #5 clk = ~clk;

    // Baud tick: one-cycle pulse every 4 clocks, changed just after the rising edge.
    always @(posedge clk) begin
        #1;
        tick_div = (tick_div + 1) % 4;
        s_tick = tick_en && (tick_div == 0);
    end

    // Count done pulses of both instances.
    always @(negedge clk) begin
        if (done_a === 1'b1) done_cnt_a++;
        if (done_b === 1'b1) done_cnt_b++;
    end

    // Global time limit.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    typedef struct {
        bit          which;   // 0 = dut_a (1 stop), 1 = dut_b (2 stop)
        logic [7:0]  data;
        int          nbits;   // serial bits in the frame
        logic [10:0] line;    // expected line level, bit i = i-th serial bit
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic start_frame(input bit which, input logic [7:0] d);
        @(negedge clk);
        if (which) begin data_b = d; start_b = 1'b1; end
        else       begin data_a = d; start_a = 1'b1; end
        @(posedge clk);
        #1;
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    task automatic wait_tick(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (s_tick === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic check_bits(input bit which, input logic [10:0] line, input int nbits,
                              input string tag);
        int  bad;
        bit  ok;
        logic tx_v, busy_v;
        for (int b = 0; b < nbits; b++) begin
            bad = 0;
            for (int t = 0; t < 16; t++) begin
                wait_tick(ok);
                if (!ok) begin
                    chk($sformatf("%s tick_timeout bit%0d", tag, b), 32'd0, 32'd1);
                    return;
                end
                tx_v   = which ? tx_b : tx_a;
                busy_v = which ? busy_b : busy_a;
                if (tx_v !== line[b]) bad++;
                if (busy_v !== 1'b1) bad++;
            end
            chk($sformatf("%s bit%0d bad_samples", tag, b), bad, 0);
        end
    endtask

    task automatic check_done(input bit which, input string tag);
        @(negedge clk);
        chk($sformatf("%s done_pulse", tag), which ? done_b : done_a, 1);
        chk($sformatf("%s busy_after", tag), which ? busy_b : busy_a, 0);
        chk($sformatf("%s tx_idle", tag), which ? tx_b : tx_a, 1);
        @(negedge clk);
        chk($sformatf("%s done_one_cycle", tag), which ? done_b : done_a, 0);
    endtask

    vec_t vecs[4];

    initial begin
        int   n0;
        int   bad;
        logic hold;

        vecs[0] = '{which: 1'b0, data: 8'h55, nbits: 10, line: 11'b01010101010};
        vecs[1] = '{which: 1'b0, data: 8'hFF, nbits: 10, line: 11'b01111111110};
        vecs[2] = '{which: 1'b1, data: 8'hA3, nbits: 11, line: 11'b11101000110};
        vecs[3] = '{which: 1'b1, data: 8'hC5, nbits: 11, line: 11'b11110001010};

        // Reset state.
        repeat (3) @(negedge clk);
        chk("reset tx_a", tx_a, 1);
        chk("reset busy_a", busy_a, 0);
        chk("reset done_a", done_a, 0);
        chk("reset tx_b", tx_b, 1);
        chk("reset busy_b", busy_b, 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("idle tx_a", tx_a, 1);

        // Table-driven frames.
        for (int v = 0; v < 4; v++) begin
            start_frame(vecs[v].which, vecs[v].data);
            chk($sformatf("vec%0d start_latency", v), vecs[v].which ? tx_b : tx_a, 0);
            check_bits(vecs[v].which, vecs[v].line, vecs[v].nbits, $sformatf("vec%0d", v));
            check_done(vecs[v].which, $sformatf("vec%0d", v));
        end

        // Request and data changes while busy are ignored.
        n0 = done_cnt_a;
        start_frame(1'b0, 8'h00);
        fork
            check_bits(1'b0, 11'b01000000000, 10, "ignore");
            begin
                repeat (200) @(negedge clk);
                data_a = 8'hFF;
                start_a = 1'b1;
                @(negedge clk);
                start_a = 1'b0;
                repeat (100) @(negedge clk);
                data_a = 8'hAA;
            end
        join
        check_done(1'b0, "ignore");
        bad = 0;
        repeat (200) begin
            @(negedge clk);
            if (busy_a !== 1'b0 || tx_a !== 1'b1) bad++;
        end
        chk("ignore no_second_frame", bad, 0);
        chk("ignore done_count", done_cnt_a - n0, 1);

        // Back-to-back frames: request in the done cycle.
        n0 = done_cnt_a;
        start_frame(1'b0, 8'h55);
        check_bits(1'b0, 11'b01010101010, 10, "b2b1");
        @(negedge clk);
        chk("b2b1 done_pulse", done_a, 1);
        data_a = 8'h0F;
        start_a = 1'b1;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        chk("b2b start_next_cycle", tx_a, 0);
        chk("b2b busy_again", busy_a, 1);
        check_bits(1'b0, 11'b01000011110, 10, "b2b2");
        check_done(1'b0, "b2b2");
        @(negedge clk);
        chk("b2b done_count", done_cnt_a - n0, 2);

        // Tick stall mid-DATA: line holds, frame resumes intact.
        start_frame(1'b0, 8'h33);
        fork
            check_bits(1'b0, 11'b01001100110, 10, "stall");
            begin
                repeat (300) @(negedge clk);
                tick_en = 1'b0;
                @(posedge clk);
                #2;
                hold = tx_a;
                bad = 0;
                repeat (100) begin
                    @(negedge clk);
                    if (tx_a !== hold || busy_a !== 1'b1) bad++;
                end
                chk("stall hold", bad, 0);
                tick_en = 1'b1;
            end
        join
        check_done(1'b0, "stall");

        // Async reset mid-DATA aborts the frame immediately.
        n0 = done_cnt_a;
        start_frame(1'b0, 8'h55);
        repeat (400) @(negedge clk);
        chk("rst pre tx_a", tx_a, 0);
        rst_n = 1'b0;
        #1;
        chk("rst async tx_a", tx_a, 1);
        chk("rst async busy_a", busy_a, 0);
        chk("rst async done_a", done_a, 0);
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (100) @(negedge clk);
        chk("rst post busy_a", busy_a, 0);
        chk("rst post tx_a", tx_a, 1);
        chk("rst no_done", done_cnt_a - n0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
